serdes_tx_serializer: RTL and testbench

//  - TX-side counterpart of the RX CDR: turns WIDTH-bit parallel words into the Serial bit stream the far-end CDR locks to.
//  - Sends a clock-rich training preamble after reset, then user words, or IDLE_WORD when no word is waiting.
//  - Sits between the TX encoder (word source) and the line driver; one bit per data_clock.

---
 rtl/serdes_tx_pkg.sv | 21 ++
 rtl/serdes_tx_serializer_prbs7_gen.sv | 28 ++
 rtl/serdes_tx_serializer.sv | 115 +++++++++++
 tb/tb_serdes_tx_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_tx_pkg.sv
// serdes_tx_pkg: shared types and constants for the TX serializer and its PRBS7 source.
package serdes_tx_pkg;

   typedef enum logic [1:0] {
      ST_TRAIN = 2'b00,
      ST_IDLE  = 2'b01,
      ST_DATA  = 2'b10,
      ST_PRBS  = 2'b11
   } tx_state_e;

   localparam logic [9:0]  K28_5_RDM     = 10'b0011111010;
   // Alternating 1010... with bit 0 = 1; the top slices off WIDTH bits.
   localparam logic [31:0] TRAIN_PATTERN = 32'h5555_5555;
   localparam logic [6:0]  PRBS7_SEED    = 7'h7F;
   localparam logic [6:0]  PRBS7_TAPS    = 7'b110_0000;

   function automatic logic prbs7_feedback(input logic [6:0] state);
      return ^(state & PRBS7_TAPS);
   endfunction

endpackage

// File: rtl/serdes_tx_serializer_prbs7_gen.sv
// prbs7_gen: x^7+x^6+1 LFSR; prbs_bit is the LFSR MSB. Present only when TX_PRBS_EN is defined.
`ifdef TX_PRBS_EN
module prbs7_gen
   import serdes_tx_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic reseed,
   output logic prbs_bit
);

   logic [6:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= PRBS7_SEED;
      end else if (reseed) begin
         lfsr <= PRBS7_SEED;
      end else if (enable) begin
         lfsr <= {lfsr[5:0], prbs7_feedback(lfsr)};
      end
   end

   assign prbs_bit = lfsr[6];

endmodule
`endif

// File: rtl/serdes_tx_serializer.sv
// serdes_tx_serializer: parallel-to-serial TX with training preamble and IDLE fill;
// defining TX_PRBS_EN adds a PRBS7 test stream selected by prbs_en.
module serdes_tx_serializer
   import serdes_tx_pkg::*;
#(
   parameter int unsigned      WIDTH       = 10,
   parameter int unsigned      TRAIN_WORDS = 16,
   parameter logic [WIDTH-1:0] IDLE_WORD   = K28_5_RDM
) (
   input  logic             data_clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             prbs_en,
   output logic             Serial,
   output logic             word_start,
   output logic [1:0]       tx_state
);

   localparam int unsigned      CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_BIT   = CW'(WIDTH - 1);
   localparam logic [7:0]       LAST_TRAIN = 8'(TRAIN_WORDS - 1);
   localparam logic [WIDTH-1:0] TRAIN_WORD = TRAIN_PATTERN[WIDTH-1:0];

   tx_state_e        state, state_nxt;
   logic [CW-1:0]    bit_cnt;
   logic [7:0]       train_cnt, train_cnt_nxt;
   logic [WIDTH-1:0] shreg, word_nxt, hold;
   logic             hold_full, hold_full_nxt, ready_nxt;
   logic             boundary, accept, hold_clear, reseed;
   logic             prbs_go, prbs_bit;

`ifdef TX_PRBS_EN
   assign prbs_go = prbs_en;

   prbs7_gen u_prbs7_gen (
      .clk      (data_clock),
      .rst_n    (Reset),
      .enable   (state == ST_PRBS),
      .reseed   (reseed),
      .prbs_bit (prbs_bit)
   );
`else
   logic unused_prbs;
   assign unused_prbs = prbs_en | reseed;
   assign prbs_go     = 1'b0;
   assign prbs_bit    = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      boundary      = (bit_cnt == LAST_BIT);
      accept        = tx_valid && tx_ready;
      state_nxt     = state;
      train_cnt_nxt = train_cnt;
      word_nxt      = shreg >> 1;
      reseed        = 1'b0;
      if (boundary) begin
         word_nxt = IDLE_WORD;
         case (state)
            ST_TRAIN: begin
               if (train_cnt != LAST_TRAIN) begin
                  train_cnt_nxt = train_cnt + 8'd1;
                  word_nxt      = TRAIN_WORD;
               end else begin
                  state_nxt = hold_full ? ST_DATA : ST_IDLE;
               end
            end
            default: begin
               if (prbs_go)        state_nxt = ST_PRBS;
               else if (hold_full) state_nxt = ST_DATA;
               else                state_nxt = ST_IDLE;
            end
         endcase
         if (state_nxt == ST_DATA) word_nxt = hold;
         reseed = (state_nxt == ST_PRBS) && (state != ST_PRBS);
      end
      // A word is only drained into the shift register at a boundary into DATA.
      hold_clear    = boundary && (state_nxt == ST_DATA);
      hold_full_nxt = accept | (hold_full & ~hold_clear);
      ready_nxt     = ((state_nxt == ST_IDLE) || (state_nxt == ST_DATA)) && !hold_full_nxt;
   end

   always_ff @(posedge data_clock or negedge Reset) begin
      if (!Reset) begin
         state      <= ST_TRAIN;
         bit_cnt    <= '0;
         train_cnt  <= '0;
         shreg      <= TRAIN_WORD;
         hold_full  <= 1'b0;
         tx_ready   <= 1'b0;
         Serial     <= 1'b0;
         word_start <= 1'b0;
         tx_state   <= ST_TRAIN;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values.
         state      <= state_nxt;
         train_cnt  <= train_cnt_nxt;
         shreg      <= word_nxt;
         bit_cnt    <= boundary ? '0 : bit_cnt + 1'b1;
         hold_full  <= hold_full_nxt;
         tx_ready   <= ready_nxt;
         Serial     <= (state == ST_PRBS) ? prbs_bit : shreg[0];
         word_start <= (bit_cnt == '0) && (state != ST_PRBS);
         tx_state   <= state;
      end
   end

   // NOTE: hold data is not reset; hold_full alone says whether it is meaningful.
   always_ff @(posedge data_clock) begin
      if (accept) hold <= tx_data;
   end

endmodule

// File: tb/tb_serdes_tx_serializer.sv
// tb_serdes_tx_serializer: directed stimulus with a word-slot level reference model
// compared every cycle, plus literal checks on the deserialized word stream.
module tb_serdes_tx_serializer;

   localparam int         W       = 10;
   localparam int         TW      = 16;
   localparam logic [W-1:0] IDLE_W  = 10'h0FA;
   localparam logic [W-1:0] TRAIN_W = 10'h155;
   localparam logic [1:0] K_TRAIN = 2'b00, K_IDLE = 2'b01, K_DATA = 2'b10, K_PRBS = 2'b11;
`ifdef TX_PRBS_EN
   localparam bit PRBS_BUILT = 1'b1;
`else
   localparam bit PRBS_BUILT = 1'b0;
`endif

   logic         data_clock = 1'b0;
   logic         Reset = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         tx_valid = 1'b0;
   logic         tx_ready;
   logic         prbs_en = 1'b0;
   logic         Serial;
   logic         word_start;
   logic [1:0]   tx_state;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   serdes_tx_serializer #(.WIDTH(W), .TRAIN_WORDS(TW), .IDLE_WORD(IDLE_W)) dut (
      .data_clock (data_clock),
      .Reset      (Reset),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .prbs_en    (prbs_en),
      .Serial     (Serial),
      .word_start (word_start),
      .tx_state   (tx_state)
   );

   always #5 data_clock = ~data_clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge data_clock);
      #1;
   endtask

   // ---------------- reference model: word slots of W bits since reset release
   bit           prbs_ref[127];
   int           m_pos = 0, m_slot = 0, prbs_i = 0;
   logic [1:0]   m_kind = K_TRAIN;
   logic [W-1:0] m_word = TRAIN_W;
   logic [W-1:0] hold_q[$];
   logic         e_serial = 1'b0, e_ws = 1'b0, e_ready = 1'b0;
   logic [1:0]   e_state = K_TRAIN;

   initial begin
      for (int i = 0; i < 7; i++) prbs_ref[i] = 1'b1;
      for (int i = 7; i < 127; i++) prbs_ref[i] = prbs_ref[i-7] ^ prbs_ref[i-6];
   end

   always @(posedge data_clock or negedge Reset) begin
      if (!Reset) begin
         m_pos    <= 0;
         m_slot   <= 0;
         m_kind   <= K_TRAIN;
         m_word   <= TRAIN_W;
         prbs_i   <= 0;
         hold_q.delete();
         e_serial <= 1'b0;
         e_ws     <= 1'b0;
         e_state  <= K_TRAIN;
         e_ready  <= 1'b0;
      end else begin : step
         int           nslot, npi;
         logic [1:0]   nkind;
         logic [W-1:0] nword;
         nslot = m_slot;
         nkind = m_kind;
         nword = m_word;
         npi   = prbs_i;
         if (m_kind == K_PRBS) begin
            e_serial <= prbs_ref[prbs_i % 127];
            e_ws     <= 1'b0;
            npi      = prbs_i + 1;
         end else begin
            e_serial <= m_word[m_pos];
            e_ws     <= (m_pos == 0);
         end
         e_state <= m_kind;
         if (m_pos == W - 1) begin
            nslot = m_slot + 1;
            if (nslot < TW) begin
               nkind = K_TRAIN;
               nword = TRAIN_W;
            end else if (PRBS_BUILT && prbs_en && m_kind != K_TRAIN) begin
               if (m_kind != K_PRBS) npi = 0;
               nkind = K_PRBS;
            end else if (hold_q.size() > 0) begin
               nkind = K_DATA;
               nword = hold_q.pop_front();
            end else begin
               nkind = K_IDLE;
               nword = IDLE_W;
            end
         end
         if (tx_valid && e_ready) hold_q.push_back(tx_data);
         m_pos   <= (m_pos + 1) % W;
         m_slot  <= nslot;
         m_kind  <= nkind;
         m_word  <= nword;
         prbs_i  <= npi;
         e_ready <= ((nkind == K_IDLE) || (nkind == K_DATA)) && (hold_q.size() == 0);
      end
   end

   always @(negedge data_clock) begin
      if (chk_en) begin
         check("serial", Serial, e_serial);
         check("word_start", word_start, e_ws);
         check("tx_state", tx_state, e_state);
         check("tx_ready", tx_ready, e_ready);
      end
   end

   // ---------------- deserializer: {state at bit 0, word} per completed word
   logic [11:0]  rx_q[$];
   bit           prbs_q[$];
   int           col_n = 0;
   logic [W-1:0] col_w = '0;
   logic [1:0]   col_st = 2'b00;

   always @(negedge data_clock) begin
      if (!Reset) begin
         col_n <= 0;
      end else if (word_start) begin
         col_w  <= {{(W-1){1'b0}}, Serial};
         col_st <= tx_state;
         col_n  <= 1;
      end else if (col_n > 0) begin
         if (col_n == W - 1) begin
            rx_q.push_back({col_st, Serial, col_w[W-2:0]});
            col_n <= 0;
         end else begin
            col_w[col_n] <= Serial;
            col_n        <= col_n + 1;
         end
      end
      if (Reset && tx_state == K_PRBS) prbs_q.push_back(Serial);
   end

   // ---------------- stimulus helpers
   task automatic wait_ready(input string name);
      for (int i = 0; i < 40 && tx_ready !== 1'b1; i++) tick();
      check(name, tx_ready, 1'b1);
   endtask

   task automatic send_word(input logic [W-1:0] w, input string name);
      tx_data = w;
      wait_ready(name);
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_model(input logic [1:0] kind, input int pos, input string name);
      for (int i = 0; i < 60 && !(m_kind == kind && m_pos == pos); i++) tick();
      check(name, {m_kind, 8'(m_pos)}, {kind, 8'(pos)});
   endtask

   task automatic check_training(input string name);
      check({name, "_rx_count"}, 32'(rx_q.size() >= TW + 1), 32'd1);
      if (rx_q.size() >= TW + 1) begin
         for (int i = 0; i < TW; i++) check({name, "_train_word"}, rx_q[i], {K_TRAIN, TRAIN_W});
         check({name, "_first_idle"}, rx_q[TW], {K_IDLE, IDLE_W});
      end
   endtask

   initial begin
      int first_idx, last_idx, cnt;
      logic [13:0] p14;
      p14 = 14'b1_000000_1111111;

      // ---- reset held for 3 cycles
      Reset = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      check("rst_serial", Serial, 1'b0);
      check("rst_word_start", word_start, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_tx_state", tx_state, K_TRAIN);
      Reset = 1'b1;

      // ---- 1: training preamble then IDLE
      repeat (175) tick();
      check_training("t1");

      // ---- 2: single word 2A5
      rx_q.delete();
      send_word(10'h2A5, "t2_ready");
      repeat (30) tick();
      first_idx = -1;
      foreach (rx_q[i]) if (first_idx < 0 && rx_q[i][11:10] == K_DATA) first_idx = i;
      check("t2_found", 32'(first_idx >= 0 && first_idx + 1 < rx_q.size()), 32'd1);
      if (first_idx >= 0 && first_idx + 1 < rx_q.size()) begin
         check("t2_data_word", rx_q[first_idx], {K_DATA, 10'h2A5});
         check("t2_then_idle", rx_q[first_idx+1], {K_IDLE, IDLE_W});
      end

      // ---- 3: back-to-back words 1..20
      rx_q.delete();
      tx_valid = 1'b1;
      for (int w = 1; w <= 20; w++) begin
         tx_data = W'(w);
         wait_ready("t3_ready");
         tick();
      end
      tx_valid = 1'b0;
      repeat (240) tick();
      cnt = 0;
      first_idx = -1;
      last_idx = -1;
      foreach (rx_q[i]) begin
         if (rx_q[i][11:10] == K_DATA) begin
            check("t3_word_order", rx_q[i][9:0], 32'(cnt + 1));
            cnt++;
            if (first_idx < 0) first_idx = i;
            last_idx = i;
         end
      end
      check("t3_word_count", cnt, 20);
      check("t3_no_gap", last_idx - first_idx, 19);

      // ---- 4: reset during a DATA word at bit_cnt 4; pending hold word is dropped
      send_word(10'h0F0, "t4_ready_x");
      for (int i = 0; i < 30 && m_kind != K_DATA; i++) tick();
      send_word(10'h30C, "t4_ready_y");
      wait_model(K_DATA, 4, "t4_align");
      Reset = 1'b0;
      #1;
      check("t4_rst_serial", Serial, 1'b0);
      check("t4_rst_tx_ready", tx_ready, 1'b0);
      check("t4_rst_word_start", word_start, 1'b0);
      check("t4_rst_tx_state", tx_state, K_TRAIN);
      rx_q.delete();
      repeat (3) tick();
      Reset = 1'b1;
      repeat (200) tick();
      check_training("t4");
      cnt = 0;
      foreach (rx_q[i]) if (rx_q[i][11:10] == K_DATA) cnt++;
      check("t4_no_stale_data", cnt, 0);

      // ---- 5: accept on the boundary edge, second word waits for the drain
      wait_model(K_IDLE, 9, "t5_align");
      rx_q.delete();
      tx_data  = 10'h3C3;
      tx_valid = 1'b1;
      tick();
      tx_data = 10'h11F;
      check("t5_ready_low_at_bit0", tx_ready, 1'b0);
      wait_ready("t5_ready_b");
      tick();
      tx_valid = 1'b0;
      repeat (40) tick();
      check("t5_rx_count", 32'(rx_q.size() >= 4), 32'd1);
      if (rx_q.size() >= 4) begin
         check("t5_current_idle", rx_q[0], {K_IDLE, IDLE_W});
         check("t5_idle_slot", rx_q[1], {K_IDLE, IDLE_W});
         check("t5_first_word", rx_q[2], {K_DATA, 10'h3C3});
         check("t5_second_word", rx_q[3], {K_DATA, 10'h11F});
      end

`ifdef TX_PRBS_EN
      // ---- 6: PRBS7 stream and return to IDLE
      prbs_q.delete();
      prbs_en = 1'b1;
      repeat (160) tick();
      check("t6_prbs_len", 32'(prbs_q.size() >= 141), 32'd1);
      if (prbs_q.size() >= 141) begin
         for (int i = 0; i < 14; i++) begin
            check("t6_prbs_head", prbs_q[i], p14[i]);
            check("t6_prbs_period", prbs_q[i+127], p14[i]);
         end
      end
      prbs_en = 1'b0;
      rx_q.delete();
      repeat (30) tick();
      check("t6_rx_count", 32'(rx_q.size() >= 1), 32'd1);
      if (rx_q.size() >= 1) check("t6_back_to_idle", rx_q[0], {K_IDLE, IDLE_W});
`else
      // prbs_en is ignored without the PRBS build
      prbs_en = 1'b1;
      rx_q.delete();
      repeat (30) tick();
      prbs_en = 1'b0;
      check("t6_rx_count", 32'(rx_q.size() >= 2), 32'd1);
      if (rx_q.size() >= 2) check("t6_prbs_ignored", rx_q[1], {K_IDLE, IDLE_W});
      check("t6_p14_pin", {31'd0, prbs_ref[13]}, {31'd0, p14[13]});
`endif

      repeat (5) tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
